hd44780_responder: RTL and testbench
====================================

# hd44780_responder

Synthesizable LCD-side model of the HD44780 4-bit parallel bus: the responder that `lcd_interface` drives. It:

- samples E/RW/RS/DB7..4 from an initiator,
- assembles nibbles into instructions or data,
- keeps address counter, DDRAM and busy flag,
- drives the busy-flag/AC and data-read nibbles back on read strobes.

It sits in loopback builds and in benches in place of the physical display, and exposes a DDRAM debug read port so the displayed text can be checked.

## Interface
- `BUSY_CYCLES`, default 1000: `sys_clk` cycles busy after a normal instruction or data write (37 µs at 27 MHz).
- `CLR_BUSY_CYCLES`, default 41000: busy cycles after clear display / return home.
- `sys_clk`  in  1  system clock; one clock domain.
- `sys_rst`  in  1  reset, synchronous, active-high.
- `i_E`  in  1  enable strobe from the initiator; asynchronous to `sys_clk`.
- `i_RW`  in  1  1 = read, 0 = write.
- `i_RS`  in  1  0 = instruction/status, 1 = data.
- `i_lcd_data`  in  4  DB7..DB4 from the initiator.
- `o_lcd_data`  out  4  read nibble.
- `o_lcd_oe`  out  1  drive enable for `o_lcd_data`.
- `o_busy`  out  1  internal busy flag.
- `o_ac`  out  7  address counter.
- `o_byte_valid`  out  1  one-cycle pulse per accepted byte.
- `o_byte_rs`  out  1  RS of the accepted byte.
- `o_byte`  out  8  the accepted byte.
- `o_bus_err`  out  1  one-cycle pulse when a write completes while busy, or a data write targets an invalid address.
- `i_dbg_addr`  in  7  DDRAM debug read address, in AC encoding.
- `o_dbg_data`  out  8  DDRAM byte at `i_dbg_addr`; 1-cycle latency.

## Operation
- **Input synchronizer**
  - E, RW, RS and data pass through 2-flop synchronizers.
  - A rise or fall of E is detected on the synchronized E.
- **Interface mode**
  - Reset mode is 8-bit (DL=1).
  - In 8-bit mode, each E fall with RW=0 completes the byte {nibble, 4'h0}.
  - Function set (0b001x_xxxx) with DL=0 switches to 4-bit mode.
  - In 4-bit mode, a nibble-phase bit alternates: high nibble first, then low nibble. A byte completes on the second E fall.
- **Writes, RS=0 (instruction decode):**
  - 0x01 clear: fill all 80 DDRAM bytes with 0x20, one per cycle; AC=0; I/D=1; busy = `CLR_BUSY_CYCLES`.
  - 0x02/0x03 home: AC=0; busy = `CLR_BUSY_CYCLES`.
  - 0x04–0x07 entry mode: store I/D (bit1). Shift (bit0) is stored and ignored.
  - 0x08–0x0F display control: store D/C/B.
  - 0x10–0x1F shift: with S/C=0, move AC per R/L; S/C=1 is ignored.
  - 0x20–0x3F function set: store DL, N, F.
  - 0x40–0x7F CGRAM address: accepted, no effect.
  - 0x80–0xFF: AC = byte[6:0].
- **Writes, RS=1 (data):**
  - DDRAM[idx(AC)] = byte, then AC steps per I/D.
  - idx = AC[6] ? 40 + AC[5:0] : AC[5:0].
  - Valid AC ranges are 0x00–0x27 and 0x40–0x67.
- **AC stepping (wrap)**
  - Increment: 0x27→0x40, 0x67→0x00.
  - Decrement: 0x00→0x67, 0x40→0x27.
  - A data write at an invalid AC (0x28–0x3F, 0x68–0x7F) is dropped, pulses `o_bus_err`, and leaves AC unchanged.
- **Busy flag**
  - Every accepted byte loads the busy counter. `o_busy` = counter ≠ 0.
  - A byte completed while busy is discarded: no state change, `o_bus_err` pulse, `o_byte_valid` = 0.
  - The nibble phase still advances on a discarded byte.
- **Reads (RW=1)**
  - The read nibble is latched on the synchronized E rise.
  - `o_lcd_oe` = synchronized E & RW.
  - RS=0: high nibble {busy, AC[6:4]}, low nibble AC[3:0].
  - RS=1: high/low nibble of DDRAM[idx(AC)]. After the low nibble, AC steps per I/D. This read is ignored while busy.
  - The phase advances on E fall. In 8-bit mode only the high nibble is returned.
- **Reset values**
  - AC=0, I/D=1, DL=1, phase=high, busy=0, D/C/B=0.
  - DDRAM = 0x20. The reset fill takes 80 cycles, during which `o_busy`=1.
  - All outputs 0 apart from `o_busy`.

## Timing
- E fall at the pins → edge detected 3 `sys_clk` later.
- The edge-detect cycle +1 produces `o_byte_valid`/`o_bus_err` and the AC/DDRAM update. `o_busy` rises in the same cycle.
- The busy counter loads to N; `o_busy` drops exactly N cycles after it rose.
- `o_lcd_data` is valid 3 cycles after the E rise at the pins. Initiators must hold E high ≥4 `sys_clk`.
- E edges closer than 3 cycles are undefined.
- Simultaneous byte completion and counter expiry: the byte counts as not-busy.
- `sys_rst` mid-byte: the phase returns to high, the partial nibble is discarded, and DDRAM refill restarts.

## Structure
- Shared package `common_pkg`:
  - `lcd_cmd_e` (instruction classes)
  - DDRAM size 80
  - line bases 0x00/0x40, line length 40
  - blank char 0x20
- Sub-module `lcd_edge_sync`: 2-flop synchronizer plus rise/fall pulses, instantiated for E and reused for RW/RS/data.
- DDRAM is an 80×8 register array inferred in the top module.

## Test plan
1. **Reset:** after 80 cycles `o_busy`=0. `i_dbg_addr`=0x00 and 0x67 → 0x20. AC=0.
2. **4-bit init:** write nibbles 3,3,3,2 then 0x28, 0x0C, 0x06, waiting out busy between each → DL=0, I/D=1, D=1. `o_byte_valid` pulses with bytes 0x30,0x30,0x30,0x20,0x28,0x0C,0x06.
3. **Data write:** write data 0x41 → DDRAM[0]=0x41, AC=1. `o_busy` high for exactly `BUSY_CYCLES`. A status read during busy returns nibbles 0x8, 0x1.
4. **Write while busy:** send 0x42 during busy → `o_bus_err` pulse, DDRAM[1] still 0x20, AC=1.
5. **Wrap:** set DDRAM address 0xA7 (AC=0x27), write 'Z' → DDRAM idx 39 = 0x5A, AC=0x40. Set 0xE7 (AC=0x67), write → AC=0x00.
6. **Clear mid-stream:** fill some text, send 0x01 → all DDRAM = 0x20, AC=0, busy for `CLR_BUSY_CYCLES`. Assert `sys_rst` between nibbles → the next nibble is treated as 8-bit mode.

Source files
------------

// File: rtl/common_pkg.sv
// Shared HD44780 types and helpers: instruction classes, DDRAM geometry,
// address-counter stepping and AC-to-DDRAM index mapping.
package common_pkg;

    localparam int         DDRAM_SIZE = 80;
    localparam int         LINE_LEN   = 40;
    localparam logic [6:0] LINE0_BASE = 7'h00;
    localparam logic [6:0] LINE1_BASE = 7'h40;
    localparam logic [6:0] LINE0_LAST = 7'h27;
    localparam logic [6:0] LINE1_LAST = 7'h67;
    localparam logic [7:0] BLANK_CHAR = 8'h20;

    typedef enum logic [3:0] {
        CMD_NOP,
        CMD_CLEAR,
        CMD_HOME,
        CMD_ENTRY,
        CMD_DISP,
        CMD_SHIFT,
        CMD_FUNC,
        CMD_CGRAM,
        CMD_DDRAM
    } lcd_cmd_e;

    typedef struct packed {
        logic dl;
        logic n;
        logic f;
        logic id;
        logic sh;
        logic d;
        logic c;
        logic b;
    } lcd_cfg_t;

    // Highest set bit selects the instruction class.
    function automatic lcd_cmd_e lcd_decode(logic [7:0] b);
        if (b[7])      return CMD_DDRAM;
        else if (b[6]) return CMD_CGRAM;
        else if (b[5]) return CMD_FUNC;
        else if (b[4]) return CMD_SHIFT;
        else if (b[3]) return CMD_DISP;
        else if (b[2]) return CMD_ENTRY;
        else if (b[1]) return CMD_HOME;
        else if (b[0]) return CMD_CLEAR;
        else           return CMD_NOP;
    endfunction

    function automatic logic ac_valid(logic [6:0] ac);
        return ac[5:0] < 6'(LINE_LEN);
    endfunction

    function automatic logic [6:0] ac_index(logic [6:0] ac);
        return ac[6] ? 7'(LINE_LEN) + {1'b0, ac[5:0]}
                     : {1'b0, ac[5:0]};
    endfunction

    function automatic logic [6:0] ac_step(logic [6:0] ac, logic inc);
        if (inc) begin
            if (ac == LINE0_LAST) return LINE1_BASE;
            if (ac == LINE1_LAST) return LINE0_BASE;
            return ac + 7'd1;
        end
        if (ac == LINE0_BASE) return LINE1_LAST;
        if (ac == LINE1_BASE) return LINE0_LAST;
        return ac - 7'd1;
    endfunction

endpackage

// File: rtl/hd44780_responder_if.sv
// HD44780 4-bit parallel bus between an initiator (master) and the
// display-side responder (slave).
interface hd44780_responder_if;

    logic       i_E;
    logic       i_RW;
    logic       i_RS;
    logic [3:0] i_lcd_data;
    logic [3:0] o_lcd_data;
    logic       o_lcd_oe;

    modport master (
        output i_E,
        output i_RW,
        output i_RS,
        output i_lcd_data,
        input  o_lcd_data,
        input  o_lcd_oe
    );

    modport slave (
        input  i_E,
        input  i_RW,
        input  i_RS,
        input  i_lcd_data,
        output o_lcd_data,
        output o_lcd_oe
    );

endinterface

// File: rtl/lcd_edge_sync.sv
// Two-flop synchronizer for a bus of async pins; bit 0 is the strobe
// and also gets single-cycle rise/fall pulses.
module lcd_edge_sync #(
    parameter int W = 1
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         rise,
    output logic         fall
);

    logic [W-1:0] s1;
    logic         s3;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            s1 <= '0;
            q  <= '0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
            s3 <= q[0];
        end
    end

    assign rise = q[0] & ~s3;
    assign fall = ~q[0] & s3;

endmodule

// File: rtl/hd44780_responder.sv
// Display-side HD44780 model: nibble assembly, instruction decode,
// address counter, 80-byte DDRAM, busy flag and read-back.
module hd44780_responder
    import common_pkg::*;
#(
    parameter int BUSY_CYCLES     = 1000,
    parameter int CLR_BUSY_CYCLES = 41000
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    hd44780_responder_if.slave lcd,
    output logic          o_busy,
    output logic [6:0]    o_ac,
    output logic          o_byte_valid,
    output logic          o_byte_rs,
    output logic [7:0]    o_byte,
    output logic          o_bus_err,
    input  logic [6:0]    i_dbg_addr,
    output logic [7:0]    o_dbg_data,
    output lcd_cfg_t      o_cfg
);

    localparam int MAXB = (BUSY_CYCLES > CLR_BUSY_CYCLES)
                        ? BUSY_CYCLES : CLR_BUSY_CYCLES;
    localparam int CW = $clog2(MAXB + 1);

    logic [6:0] sq;
    logic       e_rise;
    logic       e_fall;
    logic       e_s;
    logic       rw_s;
    logic       rs_s;
    logic [3:0] db_s;

    lcd_edge_sync #(.W(7)) u_sync (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .d       ({lcd.i_lcd_data, lcd.i_RS, lcd.i_RW, lcd.i_E}),
        .q       (sq),
        .rise    (e_rise),
        .fall    (e_fall)
    );

    assign e_s  = sq[0];
    assign rw_s = sq[1];
    assign rs_s = sq[2];
    assign db_s = sq[6:3];

    lcd_cfg_t      cfg;
    logic [6:0]    ac;
    logic          phase;
    logic [3:0]    hi_nib;
    logic [CW-1:0] busy_cnt;
    logic          fill_on;
    logic [6:0]    fill_idx;
    logic          wr_pend;
    logic          wr_rs;
    logic [7:0]    wr_byte;
    logic [3:0]    rd_nib;
    logic [7:0]    ddram [DDRAM_SIZE];

    logic          can_accept;
    logic          wr_done;
    logic          rd_done;
    logic [7:0]    asm_byte;
    logic [7:0]    cur_char;
    logic [3:0]    rd_sel;
    logic          mem_we;
    logic [6:0]    mem_addr;
    logic [7:0]    mem_wdata;

    assign o_busy = fill_on | (busy_cnt != '0);
    // A byte landing on the counter's last cycle is treated as not-busy.
    assign can_accept = !fill_on && (busy_cnt <= CW'(1));
    assign wr_done  = e_fall && !rw_s && (cfg.dl || phase);
    assign rd_done  = e_fall && rw_s && (cfg.dl || phase);
    assign asm_byte = cfg.dl ? {db_s, 4'h0} : {hi_nib, db_s};
    assign cur_char = ac_valid(ac) ? ddram[ac_index(ac)] : BLANK_CHAR;

    always_comb begin
        rd_sel = 4'h0;
        unique case ({rs_s, phase})
            2'b00: rd_sel = {o_busy, ac[6:4]};
            2'b01: rd_sel = ac[3:0];
            2'b10: rd_sel = cur_char[7:4];
            2'b11: rd_sel = cur_char[3:0];
        endcase
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = fill_idx;
        mem_wdata = BLANK_CHAR;
        if (fill_on) begin
            mem_we = 1'b1;
        end else if (wr_pend && wr_rs && can_accept && ac_valid(ac)) begin
            mem_we    = 1'b1;
            mem_addr  = ac_index(ac);
            mem_wdata = wr_byte;
        end
        if (sys_rst) mem_we = 1'b0;
    end

    always_ff @(posedge sys_clk) begin
        if (mem_we) ddram[mem_addr] <= mem_wdata;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cfg          <= '{dl: 1'b1, id: 1'b1, default: 1'b0};
            ac           <= '0;
            phase        <= 1'b0;
            hi_nib       <= '0;
            busy_cnt     <= '0;
            fill_on      <= 1'b1;
            fill_idx     <= '0;
            wr_pend      <= 1'b0;
            wr_rs        <= 1'b0;
            wr_byte      <= '0;
            rd_nib       <= '0;
            o_byte_valid <= 1'b0;
            o_byte_rs    <= 1'b0;
            o_byte       <= '0;
            o_bus_err    <= 1'b0;
            o_dbg_data   <= '0;
        end else begin
            o_byte_valid <= 1'b0;
            o_bus_err    <= 1'b0;
            wr_pend      <= wr_done;
            o_dbg_data   <= ac_valid(i_dbg_addr)
                          ? ddram[ac_index(i_dbg_addr)] : 8'h00;

            if (busy_cnt != '0) busy_cnt <= busy_cnt - CW'(1);
            if (fill_on) begin
                fill_idx <= fill_idx + 7'd1;
                if (fill_idx == 7'(DDRAM_SIZE - 1)) fill_on <= 1'b0;
            end

            if (e_fall && !cfg.dl) phase <= ~phase;
            if (e_fall && !rw_s && !cfg.dl && !phase) hi_nib <= db_s;
            if (wr_done) begin
                wr_byte <= asm_byte;
                wr_rs   <= rs_s;
            end
            if (e_rise) rd_nib <= rd_sel;
            if (rd_done && rs_s && !o_busy) ac <= ac_step(ac, cfg.id);

            if (wr_pend) begin
                if (!can_accept || (wr_rs && !ac_valid(ac))) begin
                    o_bus_err <= 1'b1;
                end else begin
                    o_byte_valid <= 1'b1;
                    o_byte_rs    <= wr_rs;
                    o_byte       <= wr_byte;
                    busy_cnt     <= CW'(BUSY_CYCLES);
                    if (wr_rs) begin
                        ac <= ac_step(ac, cfg.id);
                    end else begin
                        unique case (lcd_decode(wr_byte))
                            CMD_CLEAR: begin
                                ac       <= '0;
                                cfg.id   <= 1'b1;
                                busy_cnt <= CW'(CLR_BUSY_CYCLES);
                                fill_on  <= 1'b1;
                                fill_idx <= '0;
                            end
                            CMD_HOME: begin
                                ac       <= '0;
                                busy_cnt <= CW'(CLR_BUSY_CYCLES);
                            end
                            CMD_ENTRY: begin
                                cfg.id <= wr_byte[1];
                                cfg.sh <= wr_byte[0];
                            end
                            CMD_DISP: begin
                                cfg.d <= wr_byte[2];
                                cfg.c <= wr_byte[1];
                                cfg.b <= wr_byte[0];
                            end
                            CMD_SHIFT: begin
                                if (!wr_byte[3]) ac <= ac_step(ac, wr_byte[2]);
                            end
                            CMD_FUNC: begin
                                cfg.dl <= wr_byte[4];
                                cfg.n  <= wr_byte[3];
                                cfg.f  <= wr_byte[2];
                            end
                            CMD_DDRAM: ac <= wr_byte[6:0];
                            CMD_CGRAM, CMD_NOP: ;
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    assign lcd.o_lcd_data = rd_nib;
    assign lcd.o_lcd_oe   = e_s & rw_s;
    assign o_ac           = ac;
    assign o_cfg          = cfg;

endmodule

// File: tb/tb_hd44780_responder.sv
// Scoreboard bench for hd44780_responder: directed bus transactions,
// expected bytes and read nibbles queued, checked by a negedge monitor.
module tb_hd44780_responder;
    import common_pkg::*;

    localparam int BUSY = 60;
    localparam int CLR  = 200;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       o_busy;
    logic [6:0] o_ac;
    logic       o_byte_valid;
    logic       o_byte_rs;
    logic [7:0] o_byte;
    logic       o_bus_err;
    logic [6:0] i_dbg_addr;
    logic [7:0] o_dbg_data;
    lcd_cfg_t   o_cfg;

    always #5 sys_clk = ~sys_clk;

    hd44780_responder_if bus ();

    hd44780_responder #(
        .BUSY_CYCLES     (BUSY),
        .CLR_BUSY_CYCLES (CLR)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .lcd          (bus),
        .o_busy       (o_busy),
        .o_ac         (o_ac),
        .o_byte_valid (o_byte_valid),
        .o_byte_rs    (o_byte_rs),
        .o_byte       (o_byte),
        .o_bus_err    (o_bus_err),
        .i_dbg_addr   (i_dbg_addr),
        .o_dbg_data   (o_dbg_data),
        .o_cfg        (o_cfg)
    );

    typedef struct packed {
        logic       err;
        logic       rs;
        logic [7:0] b;
    } ev_t;

    ev_t        ev_q[$];
    logic [3:0] rd_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         busy_run = 0;
    int         last_run = 0;
    logic       oe_q = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    always @(negedge sys_clk) begin
        ev_t e;
        if (o_busy) busy_run <= busy_run + 1;
        else if (busy_run != 0) begin
            last_run <= busy_run;
            busy_run <= 0;
        end
        if (!sys_rst && (o_byte_valid || o_bus_err)) begin
            if (ev_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL byte_event: got err=%0b byte=0x%0h want none",
                         o_bus_err, o_byte);
            end else begin
                e = ev_q.pop_front();
                chk("bus_err", {31'd0, o_bus_err}, {31'd0, e.err});
                if (!e.err) begin
                    chk("byte_rs", {31'd0, o_byte_rs}, {31'd0, e.rs});
                    chk("byte", {24'd0, o_byte}, {24'd0, e.b});
                end
            end
        end
        if (oe_q && !bus.o_lcd_oe) begin
            if (rd_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rd_nib: got 0x%0h want no read",
                         bus.o_lcd_data);
            end else begin
                chk("rd_nib", {28'd0, bus.o_lcd_data},
                    {28'd0, rd_q.pop_front()});
            end
        end
        oe_q <= bus.o_lcd_oe;
    end

    task automatic pulse(input logic rw, input logic rs,
                         input logic [3:0] nib);
        bus.i_RW       = rw;
        bus.i_RS       = rs;
        bus.i_lcd_data = nib;
        @(negedge sys_clk);
        bus.i_E = 1'b1;
        repeat (5) @(negedge sys_clk);
        bus.i_E = 1'b0;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic wr4(input logic rs, input logic [7:0] b);
        pulse(1'b0, rs, b[7:4]);
        pulse(1'b0, rs, b[3:0]);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (o_busy && n < 3000) begin
            @(negedge sys_clk);
            n++;
        end
        if (o_busy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_idle: busy=1 after %0d cycles want 0", n);
        end
    endtask

    task automatic exp_ok(input logic rs, input logic [7:0] b);
        ev_q.push_back('{err: 1'b0, rs: rs, b: b});
    endtask

    task automatic exp_err();
        ev_q.push_back('{err: 1'b1, rs: 1'b0, b: 8'h00});
    endtask

    task automatic put(input logic rs, input logic [7:0] b);
        exp_ok(rs, b);
        wr4(rs, b);
        wait_idle();
    endtask

    task automatic dbg(input string nm, input logic [6:0] a,
                       input logic [7:0] exp);
        i_dbg_addr = a;
        repeat (2) @(negedge sys_clk);
        chk(nm, {24'd0, o_dbg_data}, {24'd0, exp});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_E = 1'b0;
        bus.i_RW = 1'b0;
        bus.i_RS = 1'b0;
        bus.i_lcd_data = 4'h0;
        i_dbg_addr = 7'h00;
        repeat (4) @(negedge sys_clk);
        chk("rst_ac", {25'd0, o_ac}, 32'h0);
        chk("rst_valid", {31'd0, o_byte_valid}, 32'h0);
        chk("rst_oe", {31'd0, bus.o_lcd_oe}, 32'h0);
        chk("rst_busy", {31'd0, o_busy}, 32'h1);
        sys_rst = 1'b0;
        repeat (79) @(negedge sys_clk);
        chk("fill_busy_79", {31'd0, o_busy}, 32'h1);
        @(negedge sys_clk);
        chk("fill_busy_80", {31'd0, o_busy}, 32'h0);
        dbg("dbg_rst_00", 7'h00, 8'h20);
        dbg("dbg_rst_67", 7'h67, 8'h20);
        chk("rst_dl", {31'd0, o_cfg.dl}, 32'h1);

        // 8-bit wake-up sequence, then switch to 4-bit
        for (int i = 0; i < 3; i++) begin
            exp_ok(1'b0, 8'h30);
            pulse(1'b0, 1'b0, 4'h3);
            wait_idle();
        end
        exp_ok(1'b0, 8'h20);
        pulse(1'b0, 1'b0, 4'h2);
        wait_idle();
        chk("dl_4bit", {31'd0, o_cfg.dl}, 32'h0);
        put(1'b0, 8'h28);
        put(1'b0, 8'h0C);
        put(1'b0, 8'h06);
        chk("cfg_n", {31'd0, o_cfg.n}, 32'h1);
        chk("cfg_d", {31'd0, o_cfg.d}, 32'h1);
        chk("cfg_id", {31'd0, o_cfg.id}, 32'h1);

        // data write, status read while busy, write while busy
        exp_ok(1'b1, 8'h41);
        wr4(1'b1, 8'h41);
        rd_q.push_back(4'h8);
        rd_q.push_back(4'h1);
        pulse(1'b1, 1'b0, 4'h0);
        pulse(1'b1, 1'b0, 4'h0);
        exp_err();
        wr4(1'b1, 8'h42);
        wait_idle();
        @(negedge sys_clk);
        chk("busy_len", last_run, BUSY);
        dbg("dbg_00_A", 7'h00, 8'h41);
        dbg("dbg_01_blank", 7'h01, 8'h20);
        chk("ac_after_A", {25'd0, o_ac}, 32'h01);

        // line wrap in both directions
        put(1'b0, 8'hA7);
        chk("ac_27", {25'd0, o_ac}, 32'h27);
        put(1'b1, 8'h5A);
        chk("ac_wrap_40", {25'd0, o_ac}, 32'h40);
        dbg("dbg_27_Z", 7'h27, 8'h5A);
        put(1'b0, 8'hE7);
        chk("ac_67", {25'd0, o_ac}, 32'h67);
        put(1'b1, 8'h21);
        chk("ac_wrap_00", {25'd0, o_ac}, 32'h00);
        dbg("dbg_67", 7'h67, 8'h21);
        put(1'b0, 8'hA8);
        exp_err();
        wr4(1'b1, 8'h33);
        wait_idle();
        chk("ac_invalid_kept", {25'd0, o_ac}, 32'h28);
        put(1'b0, 8'h04);
        put(1'b0, 8'h80);
        put(1'b0, 8'h10);
        chk("ac_dec_wrap", {25'd0, o_ac}, 32'h67);
        put(1'b0, 8'h06);

        // data read returns DDRAM and steps AC
        put(1'b0, 8'h80);
        rd_q.push_back(4'h4);
        rd_q.push_back(4'h1);
        pulse(1'b1, 1'b1, 4'h0);
        pulse(1'b1, 1'b1, 4'h0);
        chk("ac_after_rd", {25'd0, o_ac}, 32'h01);

        // clear display mid-stream
        put(1'b0, 8'h80);
        put(1'b1, 8'h48);
        put(1'b1, 8'h49);
        dbg("dbg_01_I", 7'h01, 8'h49);
        put(1'b0, 8'h01);
        @(negedge sys_clk);
        chk("clr_busy_len", last_run, CLR);
        chk("ac_clr", {25'd0, o_ac}, 32'h00);
        dbg("dbg_clr_00", 7'h00, 8'h20);
        dbg("dbg_clr_01", 7'h01, 8'h20);
        dbg("dbg_clr_27", 7'h27, 8'h20);
        dbg("dbg_clr_67", 7'h67, 8'h20);

        // reset between nibbles drops back to 8-bit mode
        pulse(1'b0, 1'b0, 4'h8);
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        wait_idle();
        chk("rst_mid_dl", {31'd0, o_cfg.dl}, 32'h1);
        exp_ok(1'b0, 8'h30);
        pulse(1'b0, 1'b0, 4'h3);
        wait_idle();
        chk("ac_after_rst", {25'd0, o_ac}, 32'h00);

        repeat (5) @(negedge sys_clk);
        chk("ev_q_drained", ev_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
